// File: rtl/aes_pkg.sv
// Shared AES output-path types and sizes.
package aes_pkg;

  localparam int unsigned AES_BLK_BYTES  = 16;
  localparam int unsigned AXI_BEAT_BYTES = 4;
  localparam int unsigned NBEATS         = AES_BLK_BYTES / AXI_BEAT_BYTES;
  localparam int unsigned AXI_DATA_W     = 8 * AXI_BEAT_BYTES;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_CAPT,
    S_SEND
  } out_seq_st_t;

endpackage

// File: rtl/aes_out_seq_if.sv
// AXI4-Stream beat channel carrying AES result words out of the sequencer.
interface aes_out_seq_if #(
  parameter int unsigned DATA_W = aes_pkg::AXI_DATA_W
);

  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;
  logic              tlast;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);

endinterface

// File: rtl/aes_out_seq.sv
// AES output sequencer: drains each finished 128-bit block from the 16-to-4 byte
// buffer and presents it as NBEATS 32-bit AXI4-Stream beats.
module aes_out_seq #(
  parameter int unsigned NBEATS = aes_pkg::NBEATS,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           en,
  input  logic                           aes_done,
  output logic                           out_busy,
  input  logic                           buf_empty,
  output logic                           buf_wr_en,
  output logic                           buf_req,
  input  logic [aes_pkg::AXI_DATA_W-1:0] buf_o,
  aes_out_seq_if.master                  m_axis,
  output logic [CNT_W-1:0]               blk_cnt,
  output logic                           err_overrun
);

  import aes_pkg::out_seq_st_t;
  import aes_pkg::S_IDLE;
  import aes_pkg::S_FETCH;
  import aes_pkg::S_CAPT;
  import aes_pkg::S_SEND;

  localparam int unsigned       BEAT_W    = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);

  out_seq_st_t       state;
  logic [BEAT_W-1:0] beat;

  // Buffer-facing strobes; buf_wr_en must be same-cycle with aes_done.
  always_comb begin
    out_busy  = 1'b0;
    buf_wr_en = 1'b0;
    buf_req   = 1'b0;
    out_busy  = (state != S_IDLE) | ~en;
    buf_wr_en = (state == S_IDLE) & en & aes_done & buf_empty;
    buf_req   = (state == S_FETCH);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= S_IDLE;
      beat          <= '0;
      blk_cnt       <= '0;
      err_overrun   <= 1'b0;
      m_axis.tvalid <= 1'b0;
      m_axis.tlast  <= 1'b0;
      m_axis.tdata  <= '0;
    end else begin
      // Any result the buffer did not take is lost; remember it until reset.
      if (aes_done && !buf_wr_en) begin
        err_overrun <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (buf_wr_en) begin
            state <= S_FETCH;
            beat  <= '0;
          end
        end
        S_FETCH: begin
          state <= S_CAPT;
        end
        S_CAPT: begin
          m_axis.tdata  <= buf_o;
          m_axis.tvalid <= 1'b1;
          m_axis.tlast  <= (beat == LAST_BEAT);
          state         <= S_SEND;
        end
        S_SEND: begin
          if (m_axis.tready) begin
            m_axis.tvalid <= 1'b0;
            m_axis.tlast  <= 1'b0;
            if (beat == LAST_BEAT) begin
              blk_cnt <= blk_cnt + CNT_W'(1);
              beat    <= '0;
              state   <= S_IDLE;
            end else begin
              beat  <= beat + BEAT_W'(1);
              state <= S_FETCH;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_out_seq.sv
// Directed bench for aes_out_seq with a behavioural 16-to-4 byte output buffer.
module tb_aes_out_seq;

  logic         clk = 1'b0;
  logic         resetn;
  logic         en;
  logic         aes_done;
  logic [127:0] aes_data;

  logic        out_busy, buf_wr_en, buf_req, err_overrun;
  logic [15:0] blk_cnt;
  logic        out_busy2, buf_wr_en2, buf_req2, err_overrun2;
  logic [1:0]  blk_cnt2;

  logic         buf_empty;
  logic [31:0]  buf_o;
  logic [127:0] buf_mem;
  logic [1:0]   rd_idx;
  int           req_cnt = 0;

  int checks   = 0;
  int failures = 0;

  aes_out_seq_if ifc ();
  aes_out_seq_if ifc2 ();
  assign ifc2.tready = ifc.tready;

  always #5 clk = ~clk;

  aes_out_seq #(.NBEATS(4), .CNT_W(16)) u_dut (
    .clk(clk), .resetn(resetn), .en(en), .aes_done(aes_done), .out_busy(out_busy),
    .buf_empty(buf_empty), .buf_wr_en(buf_wr_en), .buf_req(buf_req), .buf_o(buf_o),
    .m_axis(ifc.master), .blk_cnt(blk_cnt), .err_overrun(err_overrun)
  );

  // Narrow-counter twin; sees identical stimulus and the same buffer contents.
  aes_out_seq #(.NBEATS(4), .CNT_W(2)) u_dut2 (
    .clk(clk), .resetn(resetn), .en(en), .aes_done(aes_done), .out_busy(out_busy2),
    .buf_empty(buf_empty), .buf_wr_en(buf_wr_en2), .buf_req(buf_req2), .buf_o(buf_o),
    .m_axis(ifc2.master), .blk_cnt(blk_cnt2), .err_overrun(err_overrun2)
  );

  // Buffer model: 16 bytes in on wr_en, next 4 bytes to o on each req.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      buf_empty <= 1'b1;
      buf_o     <= '0;
      buf_mem   <= '0;
      rd_idx    <= '0;
    end else if (buf_wr_en) begin
      buf_mem   <= aes_data;
      buf_empty <= 1'b0;
      rd_idx    <= '0;
    end else if (buf_req) begin
      buf_o  <= buf_mem[int'(rd_idx)*32 +: 32];
      rd_idx <= rd_idx + 2'd1;
      if (rd_idx == 2'd3) buf_empty <= 1'b1;
    end
  end

  always @(posedge clk) if (resetn && buf_req) req_cnt <= req_cnt + 1;

  function automatic logic [127:0] mk_blk(input logic [7:0] base);
    logic [127:0] d;
    for (int i = 0; i < 16; i++) d[8*i +: 8] = base + 8'(i);
    return d;
  endfunction

  function automatic logic [31:0] exp_beat(input logic [7:0] base, input int k);
    logic [127:0] d;
    d = mk_blk(base);
    return d[32*k +: 32];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_block(input logic [127:0] d);
    aes_data = d;
    aes_done = 1'b1;
    step();
    aes_done = 1'b0;
  endtask

  task automatic wait_valid(output int cyc, output bit to);
    cyc = 0;
    to  = 1'b0;
    while (!ifc.tvalid) begin
      if (cyc >= 20) begin
        to = 1'b1;
        return;
      end
      step();
      cyc++;
    end
  endtask

  task automatic get_beat(output logic [31:0] d, output logic l, output int cyc, output bit to);
    wait_valid(cyc, to);
    d = ifc.tdata;
    l = ifc.tlast;
    if (!to) step();
  endtask

  task automatic reset_pulse();
    resetn = 1'b0;
    step();
    step();
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; en = 1'b1; aes_done = 1'b0; aes_data = '0; ifc.tready = 1'b0;
    step();
    step();
    checks++;
    if (ifc.tvalid !== 1'b0 || ifc.tlast !== 1'b0 || ifc.tdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_axis got v=%b l=%b d=%h exp 0/0/0", ifc.tvalid, ifc.tlast, ifc.tdata);
    end
    checks++;
    if (blk_cnt !== 16'h0 || err_overrun !== 1'b0 || blk_cnt2 !== 2'd0) begin
      failures++;
      $display("FAIL reset_cnt got cnt=%h err=%b cnt2=%h exp 0", blk_cnt, err_overrun, blk_cnt2);
    end
    checks++;
    if (out_busy !== 1'b0 || buf_req !== 1'b0 || buf_wr_en !== 1'b0) begin
      failures++;
      $display("FAIL reset_strobes got busy=%b req=%b wr=%b exp 0", out_busy, buf_req, buf_wr_en);
    end
    resetn = 1'b1;
    step();
  endtask

  task automatic test_basic();
    logic [31:0] exp [4] = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
    logic [31:0] d;
    logic        l;
    int          cyc;
    bit          to;
    ifc.tready = 1'b1;
    send_block(mk_blk(8'h00));
    for (int k = 0; k < 4; k++) begin
      get_beat(d, l, cyc, to);
      checks++;
      if (to || d !== exp[k] || l !== 1'(k == 3)) begin
        failures++;
        $display("FAIL basic_beat%0d got d=%h l=%b to=%b exp d=%h l=%b", k, d, l, to, exp[k], k == 3);
      end
      checks++;
      if (cyc != 2) begin
        failures++;
        $display("FAIL basic_latency%0d got wait=%0d exp 2", k, cyc);
      end
    end
    checks++;
    if (blk_cnt !== 16'd1 || err_overrun !== 1'b0 || ifc.tvalid !== 1'b0) begin
      failures++;
      $display("FAIL basic_done got cnt=%0d err=%b v=%b exp 1/0/0", blk_cnt, err_overrun, ifc.tvalid);
    end
  endtask

  task automatic test_stall();
    logic [31:0] d;
    logic        l;
    int          cyc;
    bit          to;
    int          r0;
    ifc.tready = 1'b1;
    send_block(mk_blk(8'h20));
    for (int k = 0; k < 2; k++) begin
      get_beat(d, l, cyc, to);
      checks++;
      if (to || d !== exp_beat(8'h20, k)) begin
        failures++;
        $display("FAIL stall_pre%0d got %h exp %h", k, d, exp_beat(8'h20, k));
      end
    end
    ifc.tready = 1'b0;
    wait_valid(cyc, to);
    r0 = req_cnt;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (to || ifc.tvalid !== 1'b1 || ifc.tdata !== 32'h2B2A2928 || ifc.tlast !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold%0d got v=%b d=%h l=%b exp 1/2b2a2928/0", i, ifc.tvalid, ifc.tdata, ifc.tlast);
      end
      step();
    end
    checks++;
    if (req_cnt != r0 || buf_req !== 1'b0) begin
      failures++;
      $display("FAIL stall_req got reqs=%0d exp %0d", req_cnt, r0);
    end
    ifc.tready = 1'b1;
    for (int k = 2; k < 4; k++) begin
      get_beat(d, l, cyc, to);
      checks++;
      if (to || d !== exp_beat(8'h20, k) || l !== 1'(k == 3)) begin
        failures++;
        $display("FAIL stall_post%0d got d=%h l=%b exp %h", k, d, l, exp_beat(8'h20, k));
      end
    end
    checks++;
    if (blk_cnt !== 16'd2) begin
      failures++;
      $display("FAIL stall_cnt got %0d exp 2", blk_cnt);
    end
  endtask

  task automatic test_overrun();
    logic [31:0] d;
    logic        l;
    int          cyc;
    bit          to;
    ifc.tready = 1'b0;
    send_block(mk_blk(8'h30));
    wait_valid(cyc, to);
    aes_data = mk_blk(8'hA0);
    aes_done = 1'b1;
    #1;
    checks++;
    if (to || buf_wr_en !== 1'b0) begin
      failures++;
      $display("FAIL overrun_wr got wr=%b to=%b exp 0", buf_wr_en, to);
    end
    step();
    aes_done = 1'b0;
    checks++;
    if (err_overrun !== 1'b1 || out_busy !== 1'b1) begin
      failures++;
      $display("FAIL overrun_flag got err=%b busy=%b exp 1/1", err_overrun, out_busy);
    end
    ifc.tready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      get_beat(d, l, cyc, to);
      checks++;
      if (to || d !== exp_beat(8'h30, k) || l !== 1'(k == 3)) begin
        failures++;
        $display("FAIL overrun_beat%0d got d=%h l=%b exp %h", k, d, l, exp_beat(8'h30, k));
      end
    end
    checks++;
    if (blk_cnt !== 16'd3 || err_overrun !== 1'b1) begin
      failures++;
      $display("FAIL overrun_cnt got cnt=%0d err=%b exp 3/1", blk_cnt, err_overrun);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] exp [4] = '{32'h13121110, 32'h17161514, 32'h1B1A1918, 32'h1F1E1D1C};
    logic [31:0] d;
    logic        l;
    int          cyc;
    bit          to;
    ifc.tready = 1'b1;
    send_block(mk_blk(8'h50));
    for (int k = 0; k < 2; k++) get_beat(d, l, cyc, to);
    ifc.tready = 1'b0;
    wait_valid(cyc, to);
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if (ifc.tvalid !== 1'b0 || ifc.tlast !== 1'b0 || ifc.tdata !== 32'h0 || buf_req !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_axis got v=%b l=%b d=%h req=%b exp 0", ifc.tvalid, ifc.tlast, ifc.tdata, buf_req);
    end
    checks++;
    if (blk_cnt !== 16'h0 || err_overrun !== 1'b0 || out_busy !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_state got cnt=%0d err=%b busy=%b exp 0", blk_cnt, err_overrun, out_busy);
    end
    step();
    step();
    resetn = 1'b1;
    ifc.tready = 1'b1;
    send_block(mk_blk(8'h10));
    for (int k = 0; k < 4; k++) begin
      get_beat(d, l, cyc, to);
      checks++;
      if (to || d !== exp[k] || l !== 1'(k == 3)) begin
        failures++;
        $display("FAIL rstmid_beat%0d got d=%h l=%b exp %h", k, d, l, exp[k]);
      end
    end
    checks++;
    if (blk_cnt !== 16'd1 || err_overrun !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_cnt got cnt=%0d err=%b exp 1/0", blk_cnt, err_overrun);
    end
    // aes_done coinciding with the final handshake is still an overrun
    send_block(mk_blk(8'h60));
    for (int k = 0; k < 3; k++) get_beat(d, l, cyc, to);
    wait_valid(cyc, to);
    aes_data = mk_blk(8'hB0);
    aes_done = 1'b1;
    #1;
    checks++;
    if (to || buf_wr_en !== 1'b0 || ifc.tlast !== 1'b1 || ifc.tdata !== 32'h6F6E6D6C) begin
      failures++;
      $display("FAIL lasths_wr got wr=%b l=%b d=%h exp 0/1/6f6e6d6c", buf_wr_en, ifc.tlast, ifc.tdata);
    end
    step();
    aes_done = 1'b0;
    checks++;
    if (err_overrun !== 1'b1 || blk_cnt !== 16'd2 || out_busy !== 1'b0 || ifc.tvalid !== 1'b0) begin
      failures++;
      $display("FAIL lasths_state got err=%b cnt=%0d busy=%b v=%b exp 1/2/0/0",
               err_overrun, blk_cnt, out_busy, ifc.tvalid);
    end
  endtask

  task automatic test_en_gate();
    logic [31:0] d;
    logic        l;
    int          cyc;
    bit          to;
    int          r0;
    reset_pulse();
    en = 1'b0;
    #1;
    checks++;
    if (out_busy !== 1'b1 || err_overrun !== 1'b0) begin
      failures++;
      $display("FAIL engate_busy got busy=%b err=%b exp 1/0", out_busy, err_overrun);
    end
    r0 = req_cnt;
    aes_data = mk_blk(8'hC0);
    aes_done = 1'b1;
    #1;
    checks++;
    if (buf_wr_en !== 1'b0) begin
      failures++;
      $display("FAIL engate_wr got %b exp 0", buf_wr_en);
    end
    step();
    aes_done = 1'b0;
    step();
    step();
    step();
    checks++;
    if (err_overrun !== 1'b1 || ifc.tvalid !== 1'b0 || req_cnt != r0) begin
      failures++;
      $display("FAIL engate_drop got err=%b v=%b reqs=%0d exp 1/0/%0d", err_overrun, ifc.tvalid, req_cnt, r0);
    end
    en = 1'b1;
    ifc.tready = 1'b1;
    send_block(mk_blk(8'h40));
    en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      get_beat(d, l, cyc, to);
      checks++;
      if (to || d !== exp_beat(8'h40, k) || l !== 1'(k == 3)) begin
        failures++;
        $display("FAIL engate_beat%0d got d=%h l=%b exp %h", k, d, l, exp_beat(8'h40, k));
      end
    end
    checks++;
    if (blk_cnt !== 16'd1 || out_busy !== 1'b1) begin
      failures++;
      $display("FAIL engate_cnt got cnt=%0d busy=%b exp 1/1", blk_cnt, out_busy);
    end
    en = 1'b1;
    #1;
    checks++;
    if (out_busy !== 1'b0) begin
      failures++;
      $display("FAIL engate_release got busy=%b exp 0", out_busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  exp2 [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    logic [31:0] d;
    logic        l;
    int          cyc;
    bit          to;
    reset_pulse();
    en = 1'b1;
    ifc.tready = 1'b1;
    for (int b = 0; b < 5; b++) begin
      send_block(mk_blk(8'(b * 16)));
      for (int k = 0; k < 4; k++) begin
        get_beat(d, l, cyc, to);
        checks++;
        if (to || d !== exp_beat(8'(b * 16), k)) begin
          failures++;
          $display("FAIL b2b_blk%0d_beat%0d got %h exp %h", b, k, d, exp_beat(8'(b * 16), k));
        end
      end
      checks++;
      if (blk_cnt2 !== exp2[b] || blk_cnt !== 16'(b + 1)) begin
        failures++;
        $display("FAIL b2b_cnt%0d got cnt2=%0d cnt=%0d exp %0d/%0d", b, blk_cnt2, blk_cnt, exp2[b], b + 1);
      end
    end
    checks++;
    if (err_overrun !== 1'b0 || err_overrun2 !== 1'b0) begin
      failures++;
      $display("FAIL b2b_err got err=%b err2=%b exp 0", err_overrun, err_overrun2);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_overrun();
    test_reset_mid();
    test_en_gate();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
